byte_op_sequencer: RTL

- Multi-cycle control stage wrapped around the byte-value manipulator, which implements MOVL/MOVLZ/MOVLS/MOVH/SWPB.
- Accepts a decoded byte-instruction request and reads the destination register from the register file.
- Drives the manipulator's op/dst_in/byte_val inputs and a single-cycle E strobe, captures dst_out, and writes the result back to the register file.
- Sits between instruction decode (upstream) and the register file (downstream); handles one instruction at a time.

---
 rtl/byte_op_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/byte_op_sequencer.sv
// Multi-cycle control stage for byte instructions (MOVL/MOVLZ/MOVLS/MOVH/SWPB).
// It reads the destination register, fires the byte manipulator once and writes the result back.
module byte_op_sequencer #(
  parameter int RF_RD_LAT = 1,
  parameter int BM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [2:0]  req_dst,
  input  logic [7:0]  req_byte,
  output logic [2:0]  rf_rd_addr,
  input  logic [15:0] rf_rd_data,
  output logic [2:0]  bm_op,
  output logic [15:0] bm_dst_in,
  output logic [7:0]  bm_byte_val,
  output logic        bm_E,
  input  logic [15:0] bm_dst_out,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_FIRE, S_WAIT, S_WB} state_t;

  localparam logic [1:0] RD_LAST = 2'(RF_RD_LAT - 1);
  localparam logic [1:0] BM_LAST = 2'(BM_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [2:0]  op_q;
  logic [2:0]  dst_q;
  logic [7:0]  byte_q;
  logic [15:0] operand_q;
  logic [15:0] result_q;
  logic        illegal_q;
  logic        accept;

  assign accept = req_valid && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (req_op > 3'd4) ? S_WB : S_READ;
      S_READ:  if (cnt_q == RD_LAST) state_d = S_FIRE;
      S_FIRE:  state_d = S_WAIT;
      S_WAIT:  if (cnt_q == BM_LAST) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are latched once at the handshake; later changes on req_* are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      byte_q    <= '0;
      operand_q <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q <= (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
      if (accept) begin
        op_q      <= req_op;
        dst_q     <= req_dst;
        byte_q    <= req_byte;
        illegal_q <= (req_op > 3'd4);
      end
      if (state_q == S_READ && cnt_q == RD_LAST) operand_q <= rf_rd_data;
      if (state_q == S_WAIT && cnt_q == BM_LAST) result_q  <= bm_dst_out;
    end
  end

  // Outputs decode only registered state, so nothing on req_* reaches rf_* or bm_* combinationally.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    rf_rd_addr  = dst_q;
    bm_op       = '0;
    bm_dst_in   = '0;
    bm_byte_val = '0;
    if (state_q inside {S_FIRE, S_WAIT, S_WB} && !illegal_q) begin
      bm_op       = op_q;
      bm_dst_in   = operand_q;
      bm_byte_val = byte_q;
    end
    bm_E       = (state_q == S_FIRE);
    done       = (state_q == S_WB);
    err        = (state_q == S_WB) && illegal_q;
    rf_wr_en   = (state_q == S_WB) && !illegal_q;
    rf_wr_addr = rf_wr_en ? dst_q    : '0;
    rf_wr_data = rf_wr_en ? result_q : '0;
  end

endmodule
